// File: rtl/ravenoc_out_arbiter.sv
// Wormhole output-port arbiter: round-robin on head flits, grant held until the
// packet's tail handshake; inputs masked off by port_en can never win.
module ravenoc_out_arbiter #(
    parameter int unsigned N_REQ = 5,
    parameter int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk_noc,
    input  logic             arst_noc,
    input  logic [N_REQ-1:0] port_en,
    input  logic [N_REQ-1:0] req_valid,
    input  logic [N_REQ-1:0] req_head,
    input  logic [N_REQ-1:0] req_tail,
    output logic [N_REQ-1:0] req_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_REQ-1:0] grant_oh,
    output logic [IDX_W-1:0] grant_idx,
    output logic             locked,
    output logic             err_no_head
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [N_REQ-1:0] grant_oh_q, grant_oh_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic             err_q, err_d;

    logic [N_REQ-1:0] cand;
    logic             found;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] scan_idx;
    int unsigned      pos;

    // Round-robin search starting just after the previous winner, wrapping at N_REQ.
    always_comb begin
        cand     = req_valid & req_head & port_en;
        found    = 1'b0;
        win_idx  = '0;
        scan_idx = '0;
        pos      = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            pos      = (32'(last_q) + k) % N_REQ;
            scan_idx = IDX_W'(pos);
            if (!found && cand[scan_idx]) begin
                found   = 1'b1;
                win_idx = scan_idx;
            end
        end
    end

    // Next-state logic plus the combinational handshake path of the locked packet.
    always_comb begin
        state_d     = state_q;
        grant_oh_d  = grant_oh_q;
        grant_idx_d = grant_idx_q;
        last_d      = last_q;
        err_d       = 1'b0;
        out_valid   = 1'b0;
        req_ready   = '0;
        case (state_q)
            ST_IDLE: begin
                err_d = |(req_valid & ~req_head & port_en);
                if (found) begin
                    state_d     = ST_LOCKED;
                    grant_oh_d  = N_REQ'(1) << win_idx;
                    grant_idx_d = win_idx;
                    last_d      = win_idx;
                end
            end
            ST_LOCKED: begin
                out_valid = req_valid[grant_idx_q];
                req_ready = grant_oh_q & {N_REQ{out_ready}};
                if (out_valid && out_ready && req_tail[grant_idx_q]) begin
                    state_d     = ST_IDLE;
                    grant_oh_d  = '0;
                    grant_idx_d = '0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                grant_oh_d  = '0;
                grant_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_noc or negedge arst_noc) begin
        if (!arst_noc) begin
            state_q     <= ST_IDLE;
            grant_oh_q  <= '0;
            grant_idx_q <= '0;
            last_q      <= IDX_W'(N_REQ - 1);
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_oh_q  <= grant_oh_d;
            grant_idx_q <= grant_idx_d;
            last_q      <= last_d;
            err_q       <= err_d;
        end
    end

    assign grant_oh    = grant_oh_q;
    assign grant_idx   = grant_idx_q;
    assign locked      = (state_q == ST_LOCKED);
    assign err_no_head = err_q;

endmodule

// File: tb/tb_ravenoc_out_arbiter.sv
// Bench for ravenoc_out_arbiter: stimulus queues the expected grant index of each
// flit handshake; a monitor pops and compares whenever a handshake happens.
module tb_ravenoc_out_arbiter;

    localparam int unsigned N = 5;
    localparam int unsigned W = 3;

    logic         clk_noc = 1'b0;
    logic         arst_noc;
    logic [N-1:0] port_en, req_valid, req_head, req_tail, req_ready, grant_oh;
    logic         out_valid, out_ready, locked, err_no_head;
    logic [W-1:0] grant_idx;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    ravenoc_out_arbiter #(.N_REQ(N), .IDX_W(W)) dut (
        .clk_noc    (clk_noc),
        .arst_noc   (arst_noc),
        .port_en    (port_en),
        .req_valid  (req_valid),
        .req_head   (req_head),
        .req_tail   (req_tail),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .grant_oh   (grant_oh),
        .grant_idx  (grant_idx),
        .locked     (locked),
        .err_no_head(err_no_head)
    );

    always #5 clk_noc = ~clk_noc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_noc);
        #1;
    endtask

    // Scoreboard monitor: every accepted flit must match the next queued grant.
    always @(negedge clk_noc) begin
        if (arst_noc === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_handshake: grant_idx=%0d at %0t", grant_idx, $time);
            end else begin
                int e;
                e = exp_q.pop_front();
                chk("hs_grant_idx", 32'(grant_idx), 32'(e));
                chk("hs_req_ready", 32'(req_ready), 32'(5'b00001 << e));
            end
        end
    end

    initial begin
        arst_noc  = 1'b0;
        port_en   = 5'b11111;
        req_valid = '0;
        req_head  = '0;
        req_tail  = '0;
        out_ready = 1'b0;
        #12;
        chk("rst_grant_oh", 32'(grant_oh), 0);
        chk("rst_grant_idx", 32'(grant_idx), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_err", 32'(err_no_head), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        step();
        arst_noc = 1'b1;

        // Reset priority: all inputs with single-flit packets, order 0,1,2,3,4,0.
        req_valid = 5'b11111; req_head = 5'b11111; req_tail = 5'b11111; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("rr_idle_before_grant", 32'(locked), 0);
            step();
            chk("rr_grant_idx", 32'(grant_idx), 32'(i % 5));
            chk("rr_locked", 32'(locked), 1);
            exp_q.push_back(i % 5);
            step();
        end
        req_valid = '0;
        step();
        chk("rr_idle_after", 32'(locked), 0);

        // Edge masking: inputs 0 and 3 disabled, order 1,2,4,1.
        port_en = 5'b10110;
        req_valid = 5'b11111; req_head = 5'b11111; req_tail = 5'b11111;
        for (int i = 0; i < 4; i++) begin
            int e;
            e = (i == 0 || i == 3) ? 1 : (i == 1 ? 2 : 4);
            step();
            chk("mask_grant_idx", 32'(grant_idx), 32'(e));
            exp_q.push_back(e);
            step();
        end
        req_valid = '0;
        port_en   = 5'b11111;
        step();

        // Wormhole lock: input 2 sends 4 flits while input 3 waits with a head.
        req_valid = 5'b01100; req_head = 5'b01100; req_tail = 5'b01000;
        step();
        chk("wh_grant_idx", 32'(grant_idx), 2);
        for (int f = 0; f < 4; f++) begin
            req_head[2] = (f == 0);
            req_tail[2] = (f == 3);
            #1;
            chk("wh_ready3", 32'(req_ready[3]), 0);
            chk("wh_ready2", 32'(req_ready[2]), 1);
            exp_q.push_back(2);
            step();
            if (f < 3) chk("wh_hold_idx", 32'(grant_idx), 2);
        end
        req_valid[2] = 1'b0;
        chk("wh_idle_after_tail", 32'(locked), 0);
        step();
        chk("wh_grant3", 32'(grant_idx), 3);
        chk("wh_locked3", 32'(locked), 1);
        exp_q.push_back(3);
        step();
        req_valid = '0;
        step();

        // Backpressure on input 4: 10 stalled cycles, then a 2-flit packet drains.
        req_valid = 5'b10000; req_head = 5'b10000; req_tail = 5'b00000; out_ready = 1'b0;
        step();
        for (int c = 0; c < 10; c++) begin
            chk("bp_out_valid", 32'(out_valid), 1);
            chk("bp_grant_idx", 32'(grant_idx), 4);
            chk("bp_req_ready", 32'(req_ready), 0);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_ready4", 32'(req_ready), 32'(5'b10000));
        exp_q.push_back(4);
        step();
        req_head = '0; req_tail = 5'b10000;
        exp_q.push_back(4);
        step();
        req_valid = '0; req_tail = '0;
        chk("bp_released", 32'(locked), 0);
        step();

        // Error pulse: input 1 valid without head for 3 cycles.
        req_valid = 5'b00010; req_head = '0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("err_pulse", 32'(err_no_head), 1);
            chk("err_no_grant", 32'(locked), 0);
        end
        req_valid = '0;
        step();
        chk("err_cleared", 32'(err_no_head), 0);

        // Mid-packet reset after the 2nd flit of a 5-flit packet on input 1.
        req_valid = 5'b00010; req_head = 5'b00010; req_tail = '0; out_ready = 1'b1;
        step();
        chk("mr_grant1", 32'(grant_idx), 1);
        exp_q.push_back(1);
        step();
        req_head = '0;
        exp_q.push_back(1);
        step();
        arst_noc = 1'b0;
        #1;
        chk("mr_grant_oh", 32'(grant_oh), 0);
        chk("mr_locked", 32'(locked), 0);
        chk("mr_req_ready", 32'(req_ready), 0);
        chk("mr_out_valid", 32'(out_valid), 0);
        step();
        arst_noc = 1'b1;
        req_valid = 5'b00011; req_head = 5'b00011; req_tail = 5'b00011;
        step();
        chk("mr_grant0", 32'(grant_idx), 0);
        exp_q.push_back(0);
        step();
        req_valid = '0;
        step();
        step();

        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ravenoc_out_arbiter.md
# ravenoc_out_arbiter

Per-output-port wormhole arbiter for the RaveNoC mesh router. It shares one router output port (N, S, W, E or Local) among up to N_REQ input ports. Arbitration is round-robin and happens on head flits. The grant stays locked to the winner until that packet's tail flit is accepted downstream. A static port-enable mask excludes inputs that face unconnected mesh edges, so those inputs can never win.

## Interface
Parameters:
- N_REQ, default 5: number of requesting input ports (N, S, W, E, Local).
- IDX_W, default $clog2(N_REQ): width of the grant index.

Ports:
- clk_noc  in  1  NoC clock; all state updates on the rising edge.
- arst_noc  in  1  reset, asynchronous, active-low.
- port_en  in  N_REQ  static enable mask; bit i = 0 means input i is never granted.
- req_valid  in  N_REQ  input i presents a flit.
- req_head  in  N_REQ  input i's flit is a head flit.
- req_tail  in  N_REQ  input i's flit is a tail flit; head and tail may both be set (single-flit packet).
- req_ready  out  N_REQ  flit on input i is accepted this cycle.
- out_valid  out  1  output port carries a flit from the granted input.
- out_ready  in  1  downstream accepts the flit.
- grant_oh  out  N_REQ  one-hot grant, drives the router data mux.
- grant_idx  out  IDX_W  binary form of grant_oh.
- locked  out  1  a packet currently owns the output port.
- err_no_head  out  1  single-cycle pulse: in IDLE, an enabled input is valid without a head flit.

## Operation
- Two states: IDLE and LOCKED. The round-robin pointer `last` (IDX_W bits) holds the index of the most recent winner.
- IDLE:
  - Candidates are inputs with req_valid & req_head & port_en.
  - The winner is the first candidate found scanning last+1, last+2, … modulo N_REQ. The wrap from N_REQ-1 to 0 is included.
  - On the clock edge with at least one candidate: grant_oh/grant_idx are loaded with the winner, last is set to the winner, and the state moves to LOCKED.
  - No candidates: remain in IDLE with grant_oh = 0.
  - err_no_head pulses for the cycle whenever any input has req_valid & ~req_head & port_en. Such inputs are ignored.
- LOCKED:
  - out_valid = req_valid[grant_idx].
  - req_ready[grant_idx] = out_ready; every other req_ready is 0.
  - A handshake is out_valid & out_ready in the same cycle.
  - A handshake whose flit has req_tail[grant_idx] set returns the state to IDLE on that edge. grant_oh clears and last is retained.
  - req_head asserted mid-packet is ignored. The lock holds until the tail.
  - Dropping port_en for the granted input does not break the lock. port_en is sampled only in IDLE.
- All req_ready are 0 in IDLE.
- out_valid is 0 in IDLE.

## Timing
- Reset (arst_noc low, asynchronous): state = IDLE, grant_oh = 0, grant_idx = 0, locked = 0, last = N_REQ-1 (input 0 has first priority), err_no_head = 0.
- Reset mid-packet: the packet is abandoned and the block returns to IDLE immediately. No flit is accepted while reset is asserted.
- Arbitration latency: a head flit presented in cycle t is granted at the edge ending t. It can be accepted in cycle t+1 at the earliest.
- out_valid and req_ready are combinational from req_valid/out_ready and the registered grant. There are no registered data paths.
- Packet overhead: a packet occupies the port from grant to tail handshake. After a tail there is exactly one IDLE cycle before the next grant, so back-to-back packets cost one bubble.
- Single-flit packet with out_ready = 1: grant in cycle t, accept in t+1, IDLE in t+2.
- Backpressure: with out_ready = 0 the grant and flit are held indefinitely. No timeout.
- Simultaneous events:
  - The tail handshake and new head requests in the same cycle are not arbitrated that cycle. The new heads are evaluated in the following IDLE cycle.
  - With all inputs requesting continuously, each input is granted once every N_REQ packets.

## Test plan
- Reset priority: release reset, then assert req_valid = req_head = 5'b11111 with port_en = all-ones. Required: grant_idx = 0 first, then 1, 2, 3, 4, 0 across successive single-flit packets, with one IDLE cycle between grants.
- Wormhole lock: input 2 sends a 4-flit packet (head, 2 body, tail) while input 3 holds a head. Required: grant_idx stays 2 for all 4 handshakes; req_ready[3] = 0 throughout; input 3 is granted 2 cycles after the tail handshake.
- Edge masking: port_en = 5'b10110 with all inputs requesting heads. Required: inputs 0 and 3 are never granted; grant order is 1, 2, 4, 1.
- Backpressure: grant input 4, hold out_ready = 0 for 10 cycles, then assert it. Required: out_valid = 1 and grant_idx = 4 stable during the stall, req_ready[4] = 0 until out_ready rises, and exactly one flit is accepted per out_ready cycle.
- Error pulse: in IDLE, input 1 presents req_valid = 1 with req_head = 0 for 3 cycles. Required: err_no_head is high for those 3 cycles and no grant occurs.
- Mid-packet reset: assert arst_noc = 0 after the 2nd flit of a 5-flit packet on input 1. Required: grant_oh = 0, locked = 0, and req_ready = 0 immediately. After release, input 0 wins over input 1 when both request.
